// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The master side requests additions; the slave side (the adder) answers.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             co;

  modport master (
    output start, a, b, ci,
    input  busy, done, sum, co
  );

  modport slave (
    input  start, a, b, ci,
    output busy, done, sum, co
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell reused over WIDTH cycles,
// framed by a start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] res_sum;
  logic             res_co;

  logic s;
  logic c;

  // The single full-adder cell; its carry-out is the only combinational path back to state.
  always_comb begin
    s = a_sr[0] ^ b_sr[0] ^ carry;
    c = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      acc_sr  <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      res_sum <= '0;
      res_co  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            carry  <= bus.ci;
            cnt    <= '0;
            acc_sr <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          acc_sr <= {s, acc_sr[WIDTH-1:1]};
          carry  <= c;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cnt    <= cnt + CW'(1);
          // The last bit's sum and carry go straight into the result registers.
          if (cnt == CNT_LAST) begin
            res_sum <= {s, acc_sr[WIDTH-1:1]};
            res_co  <= c;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = res_sum;
  assign bus.co   = res_co;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8 and WIDTH=16.
module tb_serial_adder;

  logic clk;
  logic rst_n;

  serial_adder_if #(.WIDTH(8))  bus8 ();
  serial_adder_if #(.WIDTH(16)) bus16 ();

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  serial_adder #(.WIDTH(16)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] exp_sum;
    logic       exp_co;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [32:0] actual, input logic [32:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One 8-bit addition: drive at E0, check busy for WIDTH cycles, done/result at E0+WIDTH, done low after.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic ci,
                               input logic [7:0] exp_sum, input logic exp_co,
                               input bit change_ops, input string name);
    int bad;
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    bus8.ci    = ci;
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      if (change_ops && k == 1) begin
        bus8.a = 8'h00;
        bus8.b = 8'h00;
      end
      if (bus8.busy !== 1'b1 || bus8.done !== 1'b0) bad++;
    end
    checkOutput({name, " busy window"}, 33'(bad), 33'd0);
    @(negedge clk);
    checkOutput({name, " done"}, 33'({bus8.done, bus8.busy}), 33'b10);
    checkOutput({name, " result"}, 33'({bus8.co, bus8.sum}), 33'({exp_co, exp_sum}));
    @(negedge clk);
    checkOutput({name, " done width"}, 33'(bus8.done), 33'd0);
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic ci);
    int bad;
    logic [16:0] expv;
    expv = {1'b0, a} + {1'b0, b} + 17'(ci);
    @(negedge clk);
    bus16.start = 1'b1;
    bus16.a     = a;
    bus16.b     = b;
    bus16.ci    = ci;
    @(posedge clk);
    @(negedge clk);
    bus16.start = 1'b0;
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      if (bus16.busy !== 1'b1 || bus16.done !== 1'b0) bad++;
    end
    @(negedge clk);
    if (bus16.done !== 1'b1) bad++;
    checkOutput("w16 result", 33'({bus16.co, bus16.sum}), 33'(expv));
    @(negedge clk);
    if (bus16.done !== 1'b0) bad++;
    checkOutput("w16 handshake", 33'(bad), 33'd0);
  endtask

  initial begin
    int bad;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic [8:0] rexp;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
    vecs[4] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

    rst_n = 1'b0;
    bus8.start = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.ci = 1'b0;
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.ci = 1'b0;
    #12;
    checkOutput("reset state", 33'({bus8.busy, bus8.done, bus8.co, bus8.sum}), 33'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].exp_sum, vecs[i].exp_co, 1'b0, $sformatf("vec%0d", i));

    applyStimulus(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b1, "latched operands");

    // start held high: accepts at E0 and E0+10 only
    $display("[TB] start held continuously");
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a = 8'hF0;
    bus8.b = 8'h0F;
    bus8.ci = 1'b0;
    @(posedge clk);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 2) begin
        bus8.a = 8'h01;
        bus8.b = 8'h01;
      end
      if (bus8.busy !== ((k < 8) || (k >= 10 && k < 18))) bad++;
      if (bus8.done !== (k == 8 || k == 18)) bad++;
      if (k >= 8 && k < 18 && bus8.sum !== 8'hFF) bad++;
      if (k >= 18 && bus8.sum !== 8'h02) bad++;
    end
    bus8.start = 1'b0;
    checkOutput("held start sequence", 33'(bad), 33'd0);
    checkOutput("held start final", 33'({bus8.co, bus8.sum}), 33'h002);
    repeat (2) @(negedge clk);

    // asynchronous reset mid-RUN
    $display("[TB] reset mid-run");
    bus8.start = 1'b1;
    bus8.a = 8'h0F;
    bus8.b = 8'h01;
    bus8.ci = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset outputs", 33'({bus8.busy, bus8.done, bus8.co, bus8.sum}), 33'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) bad++;
    end
    checkOutput("no done after abort", 33'(bad), 33'd0);
    applyStimulus(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, "after reset");

    $display("[TB] random sweep");
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      rexp = {1'b0, ra} + {1'b0, rb} + 9'(rc);
      applyStimulus(ra, rb, rc, rexp[7:0], rexp[8], 1'b0, "rand8");
    end
    run16(16'hFFFF, 16'h0000, 1'b1);
    run16(16'h1234, 16'hEDCB, 1'b0);
    for (int i = 0; i < 1000; i++)
      run16(16'($urandom), 16'($urandom), 1'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
